lap_sequencer: RTL
==================

# lap_sequencer

Stopwatch run/lap controller. Sits between the button edge detectors and the BCD counter/display chain. Owns the run/stop state, drives the counter enable, and records split times into a small lap memory. In recall mode it sequences stored laps onto the display bus.

## Interface
- DEPTH, 8: number of stored laps; power of two, 2..16.
- HOLD_CYC, 100_000_000: cycles a freshly captured lap is held on the display (1 s at 100 MHz).
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_p  input  1  one-cycle pulse (edge-detected start).
- stop_p  input  1  one-cycle pulse (edge-detected stop).
- split_p  input  1  one-cycle pulse (edge-detected split).
- recall_p  input  1  one-cycle pulse (edge-detected recall).
- time_bcd  input  32  live time, 8 BCD digits {hr1,hr0,min1,min0,sec1,sec0,cent1,cent0}.
- en  output  1  counter enable.
- clr  output  1  one-cycle counter clear pulse.
- disp_bcd  output  32  value for the display mux.
- disp_lap  output  1  high when disp_bcd shows a stored lap, not live time.
- lap_idx  output  $clog2(DEPTH)  index of the lap being shown.
- lap_count  output  $clog2(DEPTH)+1  number of valid laps.
- full  output  1  lap_count == DEPTH.

## Operation
- States: IDLE, RUN, STOP, RECALL.
- IDLE: start_p -> RUN, pulse clr, clear lap_count, wr_ptr and rd_ptr to 0.
- RUN (en=1):
  - stop_p -> STOP.
  - split_p with room: write time_bcd at wr_ptr, increment wr_ptr and lap_count, load hold counter with HOLD_CYC.
  - split_p when full: see Configuration.
- STOP (en=0):
  - start_p -> RUN. Laps are kept; no clr.
  - recall_p with lap_count>0 -> RECALL, lap_idx = oldest lap.
  - recall_p with lap_count==0 is ignored.
- RECALL (en=0):
  - recall_p advances lap_idx. On the last lap it returns to STOP instead.
  - stop_p -> STOP.
  - start_p -> RUN.
- Priority for simultaneous pulses:
  - RUN: stop > split; recall is ignored.
  - STOP: start > recall.
  - RECALL: start > stop > recall.
- Display:
  - disp_lap=1 while the hold counter is nonzero or the state is RECALL; disp_bcd = stored lap.
  - Otherwise disp_lap=0 and disp_bcd = time_bcd.
  - A new split during hold reloads the counter and shows the newer lap.
  - Leaving RUN clears the hold counter.
- Arithmetic:
  - wr_ptr and rd_ptr are modulo DEPTH.
  - lap_count saturates at DEPTH.
  - The oldest lap is at (wr_ptr - lap_count) mod DEPTH.

## Timing
- Reset values: state IDLE, en=0, clr=0, disp_bcd=0, disp_lap=0, lap_idx=0, lap_count=0, full=0, hold=0. Lap memory contents are don't-care.
- All outputs are registered.
- State and en change on the edge that samples the pulse: en rises 1 cycle after start_p and falls 1 cycle after stop_p.
- clr is high for exactly the cycle en first rises from IDLE.
- The capture samples time_bcd on the edge where split_p=1. lap_count, full and the held disp_bcd are valid 1 cycle later.
- The hold lasts exactly HOLD_CYC cycles after the capture edge, then disp_lap drops.
- In RECALL, disp_bcd updates 1 cycle after recall_p.
- rst mid-operation returns immediately to reset values. The lap memory is not cleared but is invalid because lap_count=0.

## Configuration
- LAP_OVERWRITE_EN defined: split_p when full overwrites the oldest lap (circular). lap_count stays DEPTH, full stays 1, and the oldest index advances.
- LAP_OVERWRITE_EN undefined: split_p when full is ignored. No write and no hold; full stays 1.

## Structure
- stopwatch_pkg holds:
  - the state enum (IDLE/RUN/STOP/RECALL);
  - BCD_W=32 and the digit-field localparams;
  - the default HOLD_CYC.
- Sub-module lap_ram: DEPTH x 32 register file, synchronous write, asynchronous read, no reset on storage.
- The FSM, pointers, hold counter and output registers live in lap_sequencer.

## Test plan
- Reset, start_p -> en=1 and clr=1 one cycle later, clr=0 the next cycle, lap_count=0.
- RUN, split_p with time_bcd=32'h00012345 -> lap_count=1, disp_lap=1, disp_bcd=32'h00012345 for HOLD_CYC (bench override 10) cycles, then live time.
- Three splits (values A, B, C), stop_p, then recall_p x3 -> disp_bcd A, B, C in turn; a 4th recall_p returns to STOP with disp_lap=0.
- DEPTH=4, five splits 1..5:
  - with LAP_OVERWRITE_EN: full=1 and recall order 2, 3, 4, 5;
  - without it: recall order 1, 2, 3, 4.
- Same-cycle stop_p and split_p in RUN -> STOP, lap_count unchanged, en=0.
- rst asserted in RECALL -> all outputs at reset values on the same edge; a following recall_p is ignored.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch run/lap control path.
//   sw_state_t        : run/lap controller states
//   BCD_W             : width of an 8-digit packed BCD time value
//   *_LSB / DIG_W     : digit field positions inside a BCD time value
//   DEFAULT_HOLD_CYC  : cycles a fresh lap stays on the display (1 s @ 100 MHz)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STOP   = 2'd2,
        RECALL = 2'd3
    } sw_state_t;

    localparam int BCD_W = 32;
    localparam int DIG_W = 4;

    // {hr1,hr0,min1,min0,sec1,sec0,cent1,cent0}
    localparam int CENT0_LSB = 0;
    localparam int CENT1_LSB = 4;
    localparam int SEC0_LSB  = 8;
    localparam int SEC1_LSB  = 12;
    localparam int MIN0_LSB  = 16;
    localparam int MIN1_LSB  = 20;
    localparam int HR0_LSB   = 24;
    localparam int HR1_LSB   = 28;

    localparam int DEFAULT_HOLD_CYC = 100_000_000;

endpackage

// File: rtl/lap_ram.sv
// -----------------------------------------------------------------------------
// lap_ram
// DEPTH x BCD_W register file holding captured split times.
// Synchronous write, asynchronous read, storage is never reset.
//   clk    : system clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data (BCD time)
//   raddr  : read address
//   rdata  : combinational read data
// -----------------------------------------------------------------------------
module lap_ram
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [BCD_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [BCD_W-1:0] rdata
);

    logic [BCD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_sequencer.sv
// -----------------------------------------------------------------------------
// lap_sequencer
// Stopwatch run/lap controller. Owns the run/stop state, drives the BCD
// counter enable/clear, captures split times into lap_ram and sequences the
// stored laps onto the display bus in recall mode.
//
// Optional feature macro: LAP_OVERWRITE_EN
//   defined   : a split while full overwrites the oldest lap (circular buffer)
//   undefined : a split while full is ignored
//
// Parameters
//   DEPTH     : number of stored laps (power of two, 2..16)
//   HOLD_CYC  : cycles a freshly captured lap is held on the display
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   start_p, stop_p, split_p, recall_p : one-cycle button pulses
//   time_bcd  : live time from the BCD counter
//   en, clr   : counter enable / one-cycle counter clear
//   disp_bcd  : value for the display mux
//   disp_lap  : disp_bcd is a stored lap rather than live time
//   lap_idx   : lap memory index of the lap being shown
//   lap_count : number of valid laps
//   full      : lap_count == DEPTH
// All outputs are registered.
// -----------------------------------------------------------------------------
module lap_sequencer
    import stopwatch_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = DEFAULT_HOLD_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_p,
    input  logic                     stop_p,
    input  logic                     split_p,
    input  logic                     recall_p,
    input  logic [BCD_W-1:0]         time_bcd,
    output logic                     en,
    output logic                     clr,
    output logic [BCD_W-1:0]         disp_bcd,
    output logic                     disp_lap,
    output logic [$clog2(DEPTH)-1:0] lap_idx,
    output logic [$clog2(DEPTH):0]   lap_count,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYC + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC);

    sw_state_t         state, state_n;
    logic [PW-1:0]     wr_ptr, wr_n;
    logic [PW-1:0]     rd_ptr, rd_n;
    logic [CW-1:0]     cnt_n;
    logic [HW-1:0]     hold, hold_n;
    logic              clr_n;
    logic              we;
    logic              cap;
    logic [BCD_W-1:0]  disp_n;
    logic              disp_lap_n;
    logic [PW-1:0]     lap_idx_n;
    logic [PW-1:0]     oldest;
    logic [PW-1:0]     newest;
    logic [BCD_W-1:0]  rdata;

    // With a full buffer the subtraction wraps to wr_ptr itself, which is
    // exactly where the oldest lap sits.
    assign oldest = wr_ptr - lap_count[PW-1:0];
    assign newest = wr_ptr - PW'(1);

    lap_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_lap_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (time_bcd),
        .raddr (rd_n),
        .rdata (rdata)
    );

    always_comb begin
        state_n    = state;
        wr_n       = wr_ptr;
        rd_n       = rd_ptr;
        cnt_n      = lap_count;
        hold_n     = hold;
        clr_n      = 1'b0;
        we         = 1'b0;
        cap        = 1'b0;

        case (state)
            IDLE: begin
                if (start_p) begin
                    state_n = RUN;
                    clr_n   = 1'b1;
                    cnt_n   = '0;
                    wr_n    = '0;
                    rd_n    = '0;
                    hold_n  = '0;
                end
            end
            RUN: begin
                hold_n = (hold != '0) ? hold - HW'(1) : '0;
                if (stop_p) begin
                    state_n = STOP;
                    hold_n  = '0;
                end else if (split_p) begin
                    if (lap_count != FULL_CNT) begin
                        we     = 1'b1;
                        cap    = 1'b1;
                        wr_n   = wr_ptr + PW'(1);
                        cnt_n  = lap_count + CW'(1);
                        hold_n = HOLD_LD;
                    end else begin
`ifdef LAP_OVERWRITE_EN
                        // Count stays saturated; advancing wr_ptr moves the
                        // oldest index along with it.
                        we     = 1'b1;
                        cap    = 1'b1;
                        wr_n   = wr_ptr + PW'(1);
                        hold_n = HOLD_LD;
`else
                        we     = 1'b0;
`endif
                    end
                end
            end
            STOP: begin
                if (start_p) begin
                    state_n = RUN;
                end else if (recall_p && lap_count != '0) begin
                    state_n = RECALL;
                    rd_n    = oldest;
                end
            end
            RECALL: begin
                if (start_p) begin
                    state_n = RUN;
                end else if (stop_p) begin
                    state_n = STOP;
                end else if (recall_p) begin
                    if (rd_ptr == newest) begin
                        state_n = STOP;
                    end else begin
                        rd_n = rd_ptr + PW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Display source selection for the next cycle
        disp_n     = time_bcd;
        disp_lap_n = 1'b0;
        lap_idx_n  = lap_idx;
        if (state_n == RECALL) begin
            disp_n     = rdata;
            disp_lap_n = 1'b1;
            lap_idx_n  = rd_n;
        end else if (hold_n != '0) begin
            disp_lap_n = 1'b1;
            if (cap) begin
                // Bypass the RAM so the captured value shows on the next cycle.
                disp_n    = time_bcd;
                lap_idx_n = wr_ptr;
            end else begin
                disp_n    = disp_bcd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold      <= '0;
            en        <= 1'b0;
            clr       <= 1'b0;
            disp_bcd  <= '0;
            disp_lap  <= 1'b0;
            lap_idx   <= '0;
            lap_count <= '0;
            full      <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            hold      <= hold_n;
            en        <= (state_n == RUN);
            clr       <= clr_n;
            disp_bcd  <= disp_n;
            disp_lap  <= disp_lap_n;
            lap_idx   <= lap_idx_n;
            lap_count <= cnt_n;
            full      <= (cnt_n == FULL_CNT);
        end
    end

endmodule
